f_fetch: RTL and testbench

Fetch stage plus F/D pipeline register for the five-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, selects the next PC from sequential or D-stage redirect (branch/j/jal/jr, delay-slot semantics), and registers instruction and PC into the decode stage that feeds the immediate extender and register file. Honours hazard-unit stall and keeps a fetched-instruction counter for debug.

---
 rtl/f_fetch_pkg.sv | 22 ++
 rtl/f_fetch_fd_reg.sv | 23 ++
 rtl/f_fetch.sv | 70 +++++++
 tb/tb_f_fetch.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/f_fetch_pkg.sv
// Constants and types shared by the fetch, decode and memory stages of the MIPS pipeline.
// The F/D payload struct keeps the pipeline-register port list compact.
package f_fetch_pkg;

    localparam logic [31:0] RESET_PC     = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
    localparam int          IM_WORD_AW   = 12;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } fd_t;

    // Word offset of a byte address inside instruction memory, before truncation.
    function automatic logic [31:0] im_word_offset(input logic [31:0] pc,
                                                   input logic [31:0] base);
        return (pc - base) >> 2;
    endfunction

endpackage

// File: rtl/f_fetch_fd_reg.sv
// F/D pipeline register: captures the fetched instruction, its PC and a valid flag.
// Enable low freezes the whole register; reset (active-low, synchronous) empties it.
module f_fetch_fd_reg
    import f_fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  fd_t  d,
    output fd_t  q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q.instr <= NOP_INSTR;
            q.pc    <= 32'h0000_0000;
            q.valid <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/f_fetch.sv
// Fetch stage: PC register, next-PC selection with D-stage redirect (delay-slot semantics),
// instruction-memory addressing and the F/D register feeding decode.
module f_fetch
    import f_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = RESET_PC,
    parameter logic [31:0] IM_BASE  = IM_BASE_ADDR,
    parameter int          IM_AW    = IM_WORD_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [31:0]      redir_pc,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      pc_f,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic             valid_d,
    output logic             adel_f,
    output logic [31:0]      fetch_cnt
);

    logic [31:0] pc_next;
    fd_t         fd_in;
    fd_t         fd_out;

    // The memory address depends only on the PC register, never on stall or redirect.
    assign im_addr = IM_AW'(im_word_offset(pc_f, IM_BASE));
    assign adel_f  = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE);

    // A redirect seen in F leaves the current (delay-slot) fetch untouched.
    always_comb begin
        pc_next = pc_f + 32'd4;
        if (redir_valid) begin
            pc_next = redir_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f      <= PC_RESET;
            fetch_cnt <= 32'h0000_0000;
        end else if (!stall) begin
            pc_f      <= pc_next;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    // A faulting fetch still travels down as a valid nop so later stages can raise the exception.
    always_comb begin
        fd_in.instr = adel_f ? NOP_INSTR : im_rdata;
        fd_in.pc    = pc_f;
        fd_in.valid = 1'b1;
    end

    f_fetch_fd_reg u_fd_reg (
        .clk   (clk),
        .reset (reset),
        .en    (!stall),
        .d     (fd_in),
        .q     (fd_out)
    );

    assign instr_d = fd_out.instr;
    assign pc_d    = fd_out.pc;
    assign valid_d = fd_out.valid;

endmodule

// File: tb/tb_f_fetch.sv
// Directed vector bench for f_fetch with a combinational instruction-memory model.
module tb_f_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [11:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        adel_f;
    logic [31:0] fetch_cnt;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_pc_f;
        logic [31:0] e_instr;
        logic [31:0] e_pc_d;
        logic        e_valid;
        logic [31:0] e_cnt;
        logic        e_adel;
        logic [11:0] e_im;
    } vec_t;

    vec_t vecs [17];

    f_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .valid_d     (valid_d),
        .adel_f      (adel_f),
        .fetch_cnt   (fetch_cnt)
    );

    assign im_rdata = mem[im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic stl, input logic rv,
                                input logic [31:0] rpc, input logic [31:0] e_pc_f,
                                input logic [31:0] e_instr, input logic [31:0] e_pc_d,
                                input logic e_valid, input logic [31:0] e_cnt,
                                input logic e_adel, input logic [11:0] e_im);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc;
        v.e_pc_f = e_pc_f; v.e_instr = e_instr; v.e_pc_d = e_pc_d;
        v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_adel = e_adel; v.e_im = e_im;
        return v;
    endfunction

    task automatic step(input logic rst, input logic stl, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset = rst; stall = stl; redir_valid = rv; redir_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 + 32'(i);
        mem[0] = 32'h3C01_0001;
        mem[1] = 32'h3421_0002;
        mem[2] = 32'h0000_0000;

        reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;

        //           rst  stl  rv   rpc            pc_f           instr          pc_d           v     cnt    adel  im
        vecs[0]  = mk(1'b0,1'b0,1'b0,32'h0,        32'h0000_3000, 32'h0,         32'h0,         1'b0, 32'd0, 1'b0, 12'h000);
        vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,        32'h0000_3004, 32'h3C01_0001, 32'h0000_3000, 1'b1, 32'd1, 1'b0, 12'h001);
        vecs[2]  = mk(1'b1,1'b0,1'b0,32'h0,        32'h0000_3008, 32'h3421_0002, 32'h0000_3004, 1'b1, 32'd2, 1'b0, 12'h002);
        vecs[3]  = mk(1'b1,1'b0,1'b1,32'h0000_3020,32'h0000_3020, 32'h0000_0000, 32'h0000_3008, 1'b1, 32'd3, 1'b0, 12'h008);
        vecs[4]  = mk(1'b1,1'b0,1'b0,32'h0,        32'h0000_3024, 32'hA500_0008, 32'h0000_3020, 1'b1, 32'd4, 1'b0, 12'h009);
        vecs[5]  = mk(1'b1,1'b0,1'b1,32'h0000_3004,32'h0000_3004, 32'hA500_0009, 32'h0000_3024, 1'b1, 32'd5, 1'b0, 12'h001);
        vecs[6]  = mk(1'b1,1'b1,1'b1,32'h0000_3040,32'h0000_3004, 32'hA500_0009, 32'h0000_3024, 1'b1, 32'd5, 1'b0, 12'h001);
        vecs[7]  = mk(1'b1,1'b1,1'b1,32'h0000_3040,32'h0000_3004, 32'hA500_0009, 32'h0000_3024, 1'b1, 32'd5, 1'b0, 12'h001);
        vecs[8]  = mk(1'b1,1'b0,1'b1,32'h0000_3040,32'h0000_3040, 32'h3421_0002, 32'h0000_3004, 1'b1, 32'd6, 1'b0, 12'h010);
        vecs[9]  = mk(1'b1,1'b0,1'b1,32'h0000_3022,32'h0000_3022, 32'hA500_0010, 32'h0000_3040, 1'b1, 32'd7, 1'b1, 12'h008);
        vecs[10] = mk(1'b1,1'b0,1'b0,32'h0,        32'h0000_3026, 32'h0000_0000, 32'h0000_3022, 1'b1, 32'd8, 1'b1, 12'h009);
        vecs[11] = mk(1'b1,1'b0,1'b1,32'h0000_3000,32'h0000_3000, 32'h0000_0000, 32'h0000_3026, 1'b1, 32'd9, 1'b0, 12'h000);
        vecs[12] = mk(1'b0,1'b1,1'b1,32'h0000_3050,32'h0000_3000, 32'h0,         32'h0,         1'b0, 32'd0, 1'b0, 12'h000);
        vecs[13] = mk(1'b1,1'b1,1'b0,32'h0,        32'h0000_3000, 32'h0,         32'h0,         1'b0, 32'd0, 1'b0, 12'h000);
        vecs[14] = mk(1'b1,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC, 32'h3C01_0001, 32'h0000_3000, 1'b1, 32'd1, 1'b0, 12'h3FF);
        vecs[15] = mk(1'b1,1'b0,1'b0,32'h0,        32'h0000_0000, 32'hA500_03FF, 32'hFFFF_FFFC, 1'b1, 32'd2, 1'b1, 12'h400);
        vecs[16] = mk(1'b1,1'b0,1'b0,32'h0,        32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'd3, 1'b1, 12'h401);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].rpc);
            chk($sformatf("v%0d pc_f", i),      pc_f,             vecs[i].e_pc_f);
            chk($sformatf("v%0d instr_d", i),   instr_d,          vecs[i].e_instr);
            chk($sformatf("v%0d pc_d", i),      pc_d,             vecs[i].e_pc_d);
            chk($sformatf("v%0d valid_d", i),   32'(valid_d),     32'(vecs[i].e_valid));
            chk($sformatf("v%0d fetch_cnt", i), fetch_cnt,        vecs[i].e_cnt);
            chk($sformatf("v%0d adel_f", i),    32'(adel_f),      32'(vecs[i].e_adel));
            chk($sformatf("v%0d im_addr", i),   32'(im_addr),     32'(vecs[i].e_im));
        end

        // im_addr must not react combinationally to stall or redirect inputs
        step(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1; redir_valid = 1'b1; redir_pc = 32'h0000_3100;
        #1 chk("nocomb redir im_addr", 32'(im_addr), 32'h0);
        stall = 1'b1;
        #1 chk("nocomb stall im_addr", 32'(im_addr), 32'h0);
        chk("nocomb pc_f", pc_f, 32'h0000_3000);

        // long stall with a pending redirect, then release
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b1, 32'h0000_3100);
            chk($sformatf("longstall%0d cnt", k),   fetch_cnt, 32'd1);
            chk($sformatf("longstall%0d pc_f", k),  pc_f,      32'h0000_3004);
            chk($sformatf("longstall%0d instr", k), instr_d,   32'h3C01_0001);
        end
        step(1'b1, 1'b0, 1'b1, 32'h0000_3100);
        chk("release pc_f", pc_f, 32'h0000_3100);
        chk("release pc_d", pc_d, 32'h0000_3004);
        chk("release instr", instr_d, 32'h3421_0002);
        chk("release cnt", fetch_cnt, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
